// File: rtl/core_brcheck_pkg.sv
// ============================================================================
// Module      : core_brcheck_pkg
// Description : Shared pipeline header for the branch checker: prediction
//               and correction record types plus target-type encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_brcheck_pkg;

    // Widths of the predictor bookkeeping carried alongside each prediction
    localparam int c_BPU_HIST_W = 8;
    localparam int c_BPU_LPHR_W = 2;
    localparam int c_BPU_RAS_W  = 3;

    // Control-transfer target kinds
    localparam logic [1:0] _BPU_TARGET_NPC    = 2'd0;
    localparam logic [1:0] _BPU_TARGET_CALL   = 2'd1;
    localparam logic [1:0] _BPU_TARGET_RETURN = 2'd2;
    localparam logic [1:0] _BPU_TARGET_IMM    = 2'd3;

    typedef struct packed {
        logic                    taken;
        logic [31:0]             target;
        logic [1:0]              target_type;
        logic [c_BPU_HIST_W-1:0] history;
        logic [c_BPU_LPHR_W-1:0] lphr;
        logic [c_BPU_RAS_W-1:0]  ras_ptr;
    } bpu_predict_t;

    typedef struct packed {
        logic                    miss;
        logic [31:0]             pc;
        logic                    true_taken;
        logic                    true_dir;
        logic [31:0]             true_target;
        logic [1:0]              true_target_type;
        logic [c_BPU_HIST_W-1:0] history;
        logic [c_BPU_LPHR_W-1:0] lphr;
        logic [c_BPU_RAS_W-1:0]  ras_ptr;
    } bpu_correct_t;

    // Architectural direction: unconditional transfers always go, others follow the resolution
    function automatic logic brcheck_actual_taken(input logic is_branch,
                                                  input logic cond,
                                                  input logic taken);
        return is_branch & (~cond | taken);
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_brcheck_perf.sv
// ============================================================================
// Module      : core_brcheck_perf
// Description : Pair of 32-bit saturating event counters for resolved
//               branches and mispredictions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_brcheck_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_inc_i,
    input  logic        miss_inc_i,
    output logic [31:0] perf_branch_o,
    output logic [31:0] perf_miss_o
);

    localparam logic [31:0] c_SAT = 32'hFFFF_FFFF;

    logic [31:0] r_branch_cnt;
    logic [31:0] r_miss_cnt;

    // Count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt <= 32'd0;
            r_miss_cnt   <= 32'd0;
        end else begin
            if (branch_inc_i && (r_branch_cnt != c_SAT)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (miss_inc_i && (r_miss_cnt != c_SAT)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign perf_branch_o = r_branch_cnt;
    assign perf_miss_o   = r_miss_cnt;

endmodule

`default_nettype wire

// File: rtl/core_brcheck.sv
// ============================================================================
// Module      : core_brcheck
// Description : Execute-stage branch resolution check. Compares the fetch
//               prediction with the resolved outcome, emits a one-cycle
//               correction/redirect and flips the fetch epoch on a miss.
//               Optional performance counters when BRCHECK_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_brcheck
    import core_brcheck_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ex_valid_i,
    input  logic         ex_stall_i,
    input  logic [31:0]  ex_pc_i,
    input  logic         ex_epoch_i,
    input  bpu_predict_t ex_predict_i,
    input  logic         ex_is_branch_i,
    input  logic         ex_cond_i,
    input  logic         ex_taken_i,
    input  logic [31:0]  ex_target_i,
    input  logic [1:0]   ex_target_type_i,
    output bpu_correct_t correct_o,
    output logic         redirect_o,
    output logic [31:0]  redirect_target_o,
    output logic         epoch_o
`ifdef BRCHECK_PERF_EN
    ,
    output logic [31:0]  perf_branch_o,
    output logic [31:0]  perf_miss_o
`endif
);

    logic         r_epoch;
    logic         r_redirect;
    logic [31:0]  r_redirect_target;
    bpu_correct_t r_correct;

    logic         w_consume;
    logic         w_actual_taken;
    logic         w_miss;
    logic [1:0]   w_true_type;

    // Only current-epoch, non-stalled instructions are examined; stale ones vanish here
    assign w_consume      = ex_valid_i & ~ex_stall_i & (ex_epoch_i == r_epoch);
    assign w_actual_taken = brcheck_actual_taken(ex_is_branch_i, ex_cond_i, ex_taken_i);

    // Direction, target (word-aligned part only) and target-kind mismatches all count as a miss.
    // A non-branch predicted taken is caught by the direction term since actual_taken is 0.
    assign w_miss = w_consume &
                    ((ex_predict_i.taken != w_actual_taken) |
                     (w_actual_taken & (ex_predict_i.target[31:2] != ex_target_i[31:2])) |
                     (ex_is_branch_i & (ex_predict_i.target_type != ex_target_type_i)));

    // A BTB alias on a non-branch must train the predictor back to plain sequential flow
    assign w_true_type = ex_is_branch_i ? ex_target_type_i : _BPU_TARGET_NPC;

    // Register the correction record and redirect; the miss pulse self-clears next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epoch           <= 1'b0;
            r_redirect        <= 1'b0;
            r_redirect_target <= 32'd0;
            r_correct         <= '0;
        end else begin
            r_redirect     <= w_miss;
            r_correct.miss <= w_miss;
            if (w_miss) begin
                r_epoch                    <= ~r_epoch;
                r_redirect_target          <= w_actual_taken ? ex_target_i : (ex_pc_i + 32'd4);
                r_correct.pc               <= ex_pc_i;
                r_correct.true_taken       <= w_actual_taken;
                r_correct.true_dir         <= ex_cond_i;
                r_correct.true_target      <= ex_target_i;
                r_correct.true_target_type <= w_true_type;
                r_correct.history          <= ex_predict_i.history;
                r_correct.lphr             <= ex_predict_i.lphr;
                r_correct.ras_ptr          <= ex_predict_i.ras_ptr;
            end
        end
    end

    assign correct_o         = r_correct;
    assign redirect_o        = r_redirect;
    assign redirect_target_o = r_redirect_target;
    assign epoch_o           = r_epoch;

`ifdef BRCHECK_PERF_EN
    core_brcheck_perf u_perf (
        .clk           (clk),
        .rst           (rst),
        .branch_inc_i  (w_consume & ex_is_branch_i),
        .miss_inc_i    (w_miss),
        .perf_branch_o (perf_branch_o),
        .perf_miss_o   (perf_miss_o)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_brcheck.sv
// ============================================================================
// Module      : tb_core_brcheck
// Description : Self-checking bench for core_brcheck: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_brcheck;
    import core_brcheck_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         ex_valid, ex_stall, ex_epoch, ex_is_branch, ex_cond, ex_taken;
    logic [31:0]  ex_pc, ex_target;
    logic [1:0]   ex_ttype;
    bpu_predict_t pred;
    bpu_correct_t correct;
    logic         redirect, epoch;
    logic [31:0]  redirect_target;
`ifdef BRCHECK_PERF_EN
    logic [31:0]  perf_branch, perf_miss;
`endif

    core_brcheck dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid_i        (ex_valid),
        .ex_stall_i        (ex_stall),
        .ex_pc_i           (ex_pc),
        .ex_epoch_i        (ex_epoch),
        .ex_predict_i      (pred),
        .ex_is_branch_i    (ex_is_branch),
        .ex_cond_i         (ex_cond),
        .ex_taken_i        (ex_taken),
        .ex_target_i       (ex_target),
        .ex_target_type_i  (ex_ttype),
        .correct_o         (correct),
        .redirect_o        (redirect),
        .redirect_target_o (redirect_target),
        .epoch_o           (epoch)
`ifdef BRCHECK_PERF_EN
        ,
        .perf_branch_o     (perf_branch),
        .perf_miss_o       (perf_miss)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bpu_correct_t m_corr;
    logic         m_redir, m_epoch;
    logic [31:0]  m_rtgt;
    logic [31:0]  m_pb, m_pm;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_corr  = '0;
        m_redir = 1'b0;
        m_epoch = 1'b0;
        m_rtgt  = 32'd0;
        m_pb    = 32'd0;
        m_pm    = 32'd0;
    endtask

    // Predict what the next clock edge produces from the currently driven inputs
    task automatic model_eval();
        logic cons, at, mis;
        cons = ex_valid && !ex_stall && (ex_epoch == m_epoch);
        at   = ex_is_branch && (!ex_cond || ex_taken);
        mis  = (pred.taken != at) ||
               (at && ((pred.target >> 2) != (ex_target >> 2))) ||
               (ex_is_branch && (pred.target_type != ex_ttype));
        m_redir     = 1'b0;
        m_corr.miss = 1'b0;
        if (cons && ex_is_branch && m_pb != 32'hFFFFFFFF) m_pb = m_pb + 1;
        if (cons && mis) begin
            if (m_pm != 32'hFFFFFFFF) m_pm = m_pm + 1;
            m_corr = '{miss: 1'b1, pc: ex_pc, true_taken: at, true_dir: ex_cond,
                       true_target: ex_target,
                       true_target_type: ex_is_branch ? ex_ttype : _BPU_TARGET_NPC,
                       history: pred.history, lphr: pred.lphr, ras_ptr: pred.ras_ptr};
            m_redir = 1'b1;
            m_rtgt  = at ? ex_target : ex_pc + 32'd4;
            m_epoch = !m_epoch;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".correct"}, 128'(correct), 128'(m_corr));
        check({tag, ".redirect"}, 128'(redirect), 128'(m_redir));
        check({tag, ".rtgt"}, 128'(redirect_target), 128'(m_rtgt));
        check({tag, ".epoch"}, 128'(epoch), 128'(m_epoch));
`ifdef BRCHECK_PERF_EN
        check({tag, ".perf_branch"}, 128'(perf_branch), 128'(m_pb));
        check({tag, ".perf_miss"}, 128'(perf_miss), 128'(m_pm));
`endif
    endtask

    task automatic cycle(input string tag);
        model_eval();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_stall = 1'b0; ex_is_branch = 1'b0; ex_cond = 1'b0;
        ex_taken = 1'b0; ex_pc = 32'd0; ex_target = 32'd0; ex_ttype = 2'd0;
        ex_epoch = 1'b0; pred = '0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic ep, input logic br, input logic cnd,
                         input logic tk, input logic [31:0] tgt, input logic [1:0] tt,
                         input logic p_tk, input logic [31:0] p_tgt, input logic [1:0] p_tt,
                         input logic [2:0] p_ras);
        ex_valid = 1'b1; ex_stall = 1'b0; ex_pc = pc; ex_epoch = ep; ex_is_branch = br;
        ex_cond = cnd; ex_taken = tk; ex_target = tgt; ex_ttype = tt;
        pred = '{taken: p_tk, target: p_tgt, target_type: p_tt, history: 8'hA5, lphr: 2'd2, ras_ptr: p_ras};
    endtask

    initial begin
        logic at;
        idle();
        model_reset();
        rst = 1'b1;
        #1;
        compare_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        cycle("idle0");

        // Conditional branch predicted not-taken, actually taken
        drive(32'h1c000040, m_epoch, 1, 1, 1, 32'h1c000100, _BPU_TARGET_IMM, 0, 32'h0, _BPU_TARGET_IMM, 3'd1);
        cycle("cond_nt_taken");
        check("cond_nt_taken.miss_k", 128'(correct.miss), 128'(1));
        check("cond_nt_taken.rtgt_k", 128'(redirect_target), 128'(32'h1c000100));
        check("cond_nt_taken.tt_k", 128'(correct.true_taken), 128'(1));
        check("cond_nt_taken.epoch_k", 128'(epoch), 128'(1));
        idle();
        cycle("pulse_clear");
        check("pulse_clear.redirect_k", 128'(redirect), 128'(0));

        // Conditional branch predicted taken, resolved not-taken
        drive(32'h1c000040, m_epoch, 1, 1, 0, 32'h1c000080, _BPU_TARGET_IMM, 1, 32'h1c000080, _BPU_TARGET_IMM, 3'd2);
        cycle("cond_t_nt");
        check("cond_t_nt.rtgt_k", 128'(redirect_target), 128'(32'h1c000044));
        check("cond_t_nt.tt_k", 128'(correct.true_taken), 128'(0));

        // Correctly predicted return
        drive(32'h1c000050, m_epoch, 1, 0, 0, 32'h1c000200, _BPU_TARGET_RETURN, 1, 32'h1c000200, _BPU_TARGET_RETURN, 3'd3);
        cycle("ret_ok");
        check("ret_ok.redirect_k", 128'(redirect), 128'(0));
        check("ret_ok.epoch_k", 128'(epoch), 128'(0));

        // Miss then an old-epoch instruction that would also miss
        drive(32'h1c000060, m_epoch, 1, 1, 1, 32'h1c000400, _BPU_TARGET_IMM, 0, 32'h0, _BPU_TARGET_IMM, 3'd0);
        cycle("b2b_first");
        check("b2b_first.redirect_k", 128'(redirect), 128'(1));
        drive(32'h1c000064, !m_epoch, 1, 1, 1, 32'h1c000500, _BPU_TARGET_IMM, 0, 32'h0, _BPU_TARGET_IMM, 3'd0);
        cycle("b2b_second");
        check("b2b_second.redirect_k", 128'(redirect), 128'(0));

        // Same target, wrong type
        drive(32'h1c000070, m_epoch, 1, 0, 0, 32'h1c000300, _BPU_TARGET_CALL, 1, 32'h1c000300, _BPU_TARGET_IMM, 3'd5);
        cycle("type_miss");
        check("type_miss.ttype_k", 128'(correct.true_target_type), 128'(_BPU_TARGET_CALL));
        check("type_miss.ras_k", 128'(correct.ras_ptr), 128'(3'd5));

        // Non-branch aliased as taken in the BTB, PC at top of address space
        drive(32'hFFFFFFFC, m_epoch, 0, 0, 0, 32'h12345678, _BPU_TARGET_CALL, 1, 32'h1c000900, _BPU_TARGET_IMM, 3'd4);
        cycle("alias");
        check("alias.ttype_k", 128'(correct.true_target_type), 128'(_BPU_TARGET_NPC));
        check("alias.rtgt_k", 128'(redirect_target), 128'(32'h0));

        // Stalled missing instruction is not consumed
        drive(32'h1c000080, m_epoch, 1, 1, 1, 32'h1c000a00, _BPU_TARGET_IMM, 0, 32'h0, _BPU_TARGET_IMM, 3'd1);
        ex_stall = 1'b1;
        cycle("stall");
        check("stall.redirect_k", 128'(redirect), 128'(0));

        // Asynchronous reset during a miss cycle
        ex_stall = 1'b0;
        cycle("pre_rst_miss");
        #1 rst = 1'b1;
        model_reset();
        #1;
        compare_all("async_rst");
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle("post_rst");

        // Reset while a miss is about to be registered discards it
        drive(32'h1c0000c0, m_epoch, 1, 1, 1, 32'h1c000b00, _BPU_TARGET_IMM, 0, 32'h0, _BPU_TARGET_IMM, 3'd1);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        compare_all("rst_discard");
        idle();
        rst = 1'b0;
        cycle("rst_discard_after");
        check("rst_discard_after.redirect_k", 128'(redirect), 128'(0));

`ifdef BRCHECK_PERF_EN
        // Three branches, one miss, counted from reset
        drive(32'h1c000100, m_epoch, 1, 0, 0, 32'h1c000200, _BPU_TARGET_CALL, 1, 32'h1c000200, _BPU_TARGET_CALL, 3'd1);
        cycle("perf_b1");
        drive(32'h1c000104, m_epoch, 1, 1, 1, 32'h1c000300, _BPU_TARGET_IMM, 0, 32'h0, _BPU_TARGET_IMM, 3'd1);
        cycle("perf_b2");
        drive(32'h1c000300, m_epoch, 1, 1, 0, 32'h1c000400, _BPU_TARGET_IMM, 0, 32'h0, _BPU_TARGET_IMM, 3'd1);
        cycle("perf_b3");
        idle();
        cycle("perf_end");
        check("perf_end.branch_k", 128'(perf_branch), 128'(32'd3));
        check("perf_end.miss_k", 128'(perf_miss), 128'(32'd1));
`endif

        // Randomized traffic, prediction correct roughly half the time
        for (int i = 0; i < 400; i++) begin
            ex_valid     = ($urandom % 8) != 0;
            ex_stall     = ($urandom % 6) == 0;
            ex_epoch     = (($urandom % 5) == 0) ? !m_epoch : m_epoch;
            ex_is_branch = ($urandom % 4) != 0;
            ex_cond      = $urandom % 2;
            ex_taken     = $urandom % 2;
            ex_pc        = $urandom;
            ex_target    = $urandom;
            ex_ttype     = 2'($urandom % 4);
            pred.history = 8'($urandom);
            pred.lphr    = 2'($urandom);
            pred.ras_ptr = 3'($urandom);
            at = ex_is_branch && (!ex_cond || ex_taken);
            if ($urandom % 2) begin
                pred.taken       = at;
                pred.target      = {ex_target[31:2], 2'($urandom)};
                pred.target_type = ex_is_branch ? ex_ttype : 2'($urandom);
            end else begin
                pred.taken       = $urandom % 2;
                pred.target      = ($urandom % 2) ? ex_target : 32'($urandom);
                pred.target_type = 2'($urandom % 4);
            end
            cycle("rand");
        end

        idle();
        cycle("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/core_brcheck.md
CORE_BRCHECK -- requirements
Module: core_brcheck

Interface
REQ-001 SHALL have clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have rst  in  1  reset, asynchronous and active-high.
REQ-003 SHALL have ex_valid_i  in  1  execute-stage instruction valid.
REQ-004 SHALL have ex_stall_i  in  1  execute stage held; the instruction is not consumed.
REQ-005 SHALL have ex_pc_i  in  32  instruction PC.
REQ-006 SHALL have ex_epoch_i  in  1  fetch epoch tag carried with the instruction.
REQ-007 SHALL have ex_predict_i  in  bpu_predict_t  prediction that fetch attached: taken, target, target_type, history, lphr, ras_ptr.
REQ-008 SHALL have ex_is_branch_i  in  1  instruction is any control transfer.
REQ-009 SHALL have ex_cond_i  in  1  control transfer is conditional.
REQ-010 SHALL have ex_taken_i  in  1  resolved direction; don't-care when ex_cond_i=0.
REQ-011 SHALL have ex_target_i  in  32  resolved target.
REQ-012 SHALL have ex_target_type_i  in  2  _BPU_TARGET_NPC/CALL/RETURN/IMM.
REQ-013 SHALL have correct_o  out  bpu_correct_t  update and recovery record to the next-PC unit.
REQ-014 SHALL have redirect_o  out  1  front-end flush request.
REQ-015 SHALL have redirect_target_o  out  32  fetch restart address.
REQ-016 SHALL have epoch_o  out  1  current epoch, which fetch tags new instructions with.

Function
REQ-017 SHALL treat an instruction as consumed when ex_valid_i=1, ex_stall_i=0 and ex_epoch_i==epoch_q.
- Epoch mismatch: instruction dropped silently.
REQ-018 SHALL compute actual_taken = ex_is_branch_i & (~ex_cond_i | ex_taken_i).
REQ-019 SHALL flag miss when any of the following holds:
- predict.taken != actual_taken;
- actual_taken and predict.target[31:2] != ex_target_i[31:2];
- ex_is_branch_i and predict.target_type != ex_target_type_i.
REQ-020 SHALL flag a non-branch predicted taken (BTB alias) as a miss, with true_target_type=_BPU_TARGET_NPC and true_taken=0.
REQ-021 SHALL register all outputs; correct_o/redirect_o are valid exactly one cycle after the consuming edge and last one cycle only.
REQ-022 SHALL on miss drive correct_o fields as follows:
- miss=1, pc=ex_pc_i, true_taken=actual_taken, true_dir=ex_cond_i;
- true_target=ex_target_i, true_target_type=ex_target_type_i;
- history, lphr and ras_ptr copied from ex_predict_i.
REQ-023 SHALL set redirect_target_o to ex_target_i if actual_taken, else ex_pc_i+4 (32-bit wrap).
REQ-024 SHALL toggle epoch_q on the edge that registers a miss, so all younger in-flight instructions are dropped until refetched.
REQ-025 SHALL drive correct_o.miss=0 and redirect_o=0 in every cycle with no registered miss.
- Payload fields hold their last value.
REQ-026 SHALL on back-to-back consumed instructions where the first misses, drop the second by epoch mismatch: one redirect only.
REQ-027 SHALL leave all state unchanged while ex_stall_i=1.

Reset
REQ-028 SHALL on rst clear the following immediately, regardless of clock: epoch_q=0, correct_o.miss=0, redirect_o=0, redirect_target_o=0, all correct_o payload=0.
REQ-029 SHALL, if rst asserts mid-operation, discard any miss being registered; no redirect after deassertion.

Configuration
REQ-030 SHALL, when BRCHECK_PERF_EN is defined, add two 32-bit saturating counters plus output ports perf_branch_o and perf_miss_o:
- perf_branch_o counts consumed branches;
- perf_miss_o counts misses;
- both reset to 0 and stick at 32'hFFFFFFFF.
REQ-031 SHALL, without BRCHECK_PERF_EN, omit the counters and ports entirely; all other behaviour is identical.

Structure
REQ-032 SHALL take bpu_predict_t, bpu_correct_t and the _BPU_TARGET_* constants from the shared pipeline header package; no local redefinition.
REQ-033 SHALL place the counters in sub-module core_brcheck_perf, instantiated only under BRCHECK_PERF_EN.

Verification
REQ-034 Cond branch predicted not-taken, taken to 0x1c000100 at pc 0x1c000040 -> next cycle miss=1, redirect_target_o=0x1c000100, true_taken=1, epoch_o toggles.
REQ-035 Cond branch predicted taken, resolved not-taken at pc 0x1c000040 -> redirect_target_o=0x1c000044, true_taken=0.
REQ-036 RETURN predicted correctly (target 0x1c000200 matches) -> no miss, no redirect, epoch unchanged.
REQ-037 Miss followed next cycle by an old-epoch branch that would also miss -> exactly one redirect; second instruction ignored.
REQ-038 Same-target branch predicted with wrong type (IMM vs CALL) -> miss with true_target_type=CALL and ras_ptr echoed from the prediction.
REQ-039 Assert rst during a miss cycle; with BRCHECK_PERF_EN, run 3 branches / 1 miss -> outputs clear asynchronously; perf_branch_o=3, perf_miss_o=1 after reset.
